// File: rtl/venda_troco_if.sv
// Coin/change bus between the coin source, the vending controller and the
// change hopper. The controller sits on the slave side.
interface venda_troco_if #(
  parameter int COIN_W = 5,
  parameter int SUM_W  = 7
);
  logic [SUM_W-1:0]  price;
  logic [COIN_W-1:0] coin;
  logic              coin_valid;
  logic              coin_ready;
  logic              coin_reject;
  logic              cancel;
  logic              vendeu;
  logic [COIN_W-1:0] chg_coin;
  logic              chg_valid;
  logic              chg_ready;
  logic [SUM_W-1:0]  soma;
  logic              busy;

  modport master (
    output price, coin, coin_valid, cancel, chg_ready,
    input  coin_ready, coin_reject, vendeu, chg_coin, chg_valid, soma, busy
  );

  modport slave (
    input  price, coin, coin_valid, cancel, chg_ready,
    output coin_ready, coin_reject, vendeu, chg_coin, chg_valid, soma, busy
  );
endinterface

// File: rtl/venda_troco.sv
// Vending controller with change return. Collects legal coins, latches the
// price on the first coin of a sale, vends once the balance covers it and
// pays back the remainder greedily, one coin per hopper handshake.
module venda_troco #(
  parameter int COIN_W = 5,
  parameter int SUM_W  = 7,
  parameter int D0     = 5,
  parameter int D1     = 10,
  parameter int D2     = 20
) (
  input logic          clk,
  input logic          reset,
  venda_troco_if.slave bus
);
  typedef enum logic [1:0] {COLLECT, CHECK, VEND, CHANGE} state_t;

  localparam logic [COIN_W-1:0] D0_C = COIN_W'(D0);
  localparam logic [COIN_W-1:0] D1_C = COIN_W'(D1);
  localparam logic [COIN_W-1:0] D2_C = COIN_W'(D2);
  localparam logic [SUM_W-1:0]  D0_S = SUM_W'(D0);
  localparam logic [SUM_W-1:0]  D1_S = SUM_W'(D1);
  localparam logic [SUM_W-1:0]  D2_S = SUM_W'(D2);

  state_t            state_q, state_n;
  logic [SUM_W-1:0]  soma_q, soma_n;
  logic [SUM_W-1:0]  price_q, price_n;
  logic              reject_q, reject_n;
  logic [SUM_W:0]    sum_w;
  logic              coin_legal;
  logic              coin_fits;
  logic [COIN_W-1:0] chg_val;
  logic [SUM_W-1:0]  chg_ext;
  logic              chg_vld;

  // Largest denomination not exceeding the balance; zero for a residue below D0.
  function automatic logic [COIN_W-1:0] greedy_coin(input logic [SUM_W-1:0] s);
    if (s >= D2_S)      return D2_C;
    else if (s >= D1_S) return D1_C;
    else if (s >= D0_S) return D0_C;
    else                return '0;
  endfunction

  // One extra bit on the sum exposes overflow instead of letting it wrap.
  assign sum_w      = (SUM_W+1)'(soma_q) + (SUM_W+1)'(bus.coin);
  assign coin_fits  = ~sum_w[SUM_W];
  assign coin_legal = (bus.coin == D0_C) || (bus.coin == D1_C) || (bus.coin == D2_C);
  assign chg_val    = greedy_coin(soma_q);
  assign chg_ext    = SUM_W'(chg_val);
  assign chg_vld    = (state_q == CHANGE) && (soma_q >= D0_S);

  // State, balance, latched price and the registered reject pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= COLLECT;
      soma_q   <= '0;
      price_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      soma_q   <= soma_n;
      price_q  <= price_n;
      reject_q <= reject_n;
    end
  end

  // Next-state, balance update and reject decision.
  always_comb begin
    state_n  = state_q;
    soma_n   = soma_q;
    price_n  = price_q;
    reject_n = 1'b0;
    case (state_q)
      COLLECT: begin
        // A cancel with money inside takes priority; a coin offered alongside is refused.
        if (bus.cancel && (soma_q != '0)) begin
          state_n  = CHANGE;
          reject_n = bus.coin_valid;
        end else if (bus.coin_valid) begin
          if (coin_legal && coin_fits) begin
            soma_n  = sum_w[SUM_W-1:0];
            if (soma_q == '0) price_n = bus.price;
            state_n = CHECK;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      CHECK: begin
        reject_n = bus.coin_valid;
        // A zero price never sells; coins just keep accumulating.
        if ((price_q != '0) && (soma_q >= price_q)) state_n = VEND;
        else                                         state_n = COLLECT;
      end
      VEND: begin
        reject_n = bus.coin_valid;
        soma_n   = soma_q - price_q;
        state_n  = (soma_q != price_q) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        reject_n = bus.coin_valid;
        // Anything below the smallest coin cannot be paid back and is dropped.
        if (soma_q < D0_S) begin
          soma_n  = '0;
          state_n = COLLECT;
        end else if (bus.chg_ready) begin
          soma_n = soma_q - chg_ext;
          if (soma_q == chg_ext) state_n = COLLECT;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  assign bus.coin_ready  = (state_q == COLLECT);
  assign bus.coin_reject = reject_q;
  assign bus.vendeu      = (state_q == VEND);
  assign bus.chg_valid   = chg_vld;
  assign bus.chg_coin    = chg_vld ? chg_val : '0;
  assign bus.soma        = soma_q;
  assign bus.busy        = (state_q != COLLECT);
endmodule

// File: tb/tb_venda_troco.sv
// Bench for venda_troco: directed scenarios plus a randomized run checked
// against a sale-level model (balance, expected vend, greedy change list).
module tb_venda_troco;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  venda_troco_if #(.COIN_W(5), .SUM_W(7)) b ();
  venda_troco_if #(.COIN_W(5), .SUM_W(5)) b5 ();

  venda_troco #(.COIN_W(5), .SUM_W(7), .D0(5), .D1(10), .D2(20)) dut (
    .clk(clk), .reset(reset), .bus(b)
  );
  venda_troco #(.COIN_W(5), .SUM_W(5), .D0(5), .D1(10), .D2(20)) dut5 (
    .clk(clk), .reset(reset), .bus(b5)
  );

  int total = 0;
  int bad = 0;
  int n_vend = 0;
  logic [4:0] chg_q[$];
  int exp_q[$];

  // Event monitor: samples between the input update at negedge and the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (reset === 1'b1) begin
      if (b.vendeu === 1'b1) n_vend++;
      if (b.chg_valid === 1'b1 && b.chg_ready === 1'b1) chg_q.push_back(b.chg_coin);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Change the model expects for an amount: largest coin first, residue dropped.
  function automatic void model_change(input int amt);
    int r;
    r = amt;
    while (r >= 5) begin
      if (r >= 20)      begin exp_q.push_back(20); r -= 20; end
      else if (r >= 10) begin exp_q.push_back(10); r -= 10; end
      else              begin exp_q.push_back(5);  r -= 5;  end
    end
  endfunction

  task automatic put_coin(input logic [4:0] c, output logic rej);
    @(negedge clk);
    b.coin = c;
    b.coin_valid = 1'b1;
    @(negedge clk);
    b.coin_valid = 1'b0;
    rej = b.coin_reject;
  endtask

  task automatic do_cancel(output logic rej);
    @(negedge clk);
    b.cancel = 1'b1;
    @(negedge clk);
    b.cancel = 1'b0;
    rej = b.coin_reject;
  endtask

  task automatic put_coin5(input logic [4:0] c, output logic rej);
    @(negedge clk);
    b5.coin = c;
    b5.coin_valid = 1'b1;
    @(negedge clk);
    b5.coin_valid = 1'b0;
    rej = b5.coin_reject;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    while (b.busy !== 1'b0 && n < 200) begin
      b.chg_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    b.chg_ready = 1'b0;
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL idle_timeout busy=%b after %0d cycles", b.busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    b.price = '0; b.coin = '0; b.coin_valid = 1'b0; b.cancel = 1'b0; b.chg_ready = 1'b0;
    b5.price = '0; b5.coin = '0; b5.coin_valid = 1'b0; b5.cancel = 1'b0; b5.chg_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (b.soma !== 7'd0) begin bad++; $display("FAIL reset_soma got=%0d want=0", b.soma); end
    total++; if (b.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", b.busy); end
    total++; if (b.vendeu !== 1'b0 || b.chg_valid !== 1'b0 || b.coin_reject !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got vendeu=%b chg_valid=%b reject=%b want 0", b.vendeu, b.chg_valid, b.coin_reject);
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (b.coin_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", b.coin_ready); end
  endtask

  task automatic test_exact_vend();
    logic rej;
    int v0;
    v0 = n_vend;
    b.price = 7'd40;
    put_coin(5'd20, rej);
    wait_idle(0);
    put_coin(5'd20, rej);
    total++; if (rej !== 1'b0) begin bad++; $display("FAIL exact_accept got reject=%b want=0", rej); end
    total++; if (b.vendeu !== 1'b0) begin bad++; $display("FAIL exact_vend_early got=%b want=0", b.vendeu); end
    @(negedge clk);
    total++; if (b.vendeu !== 1'b1) begin bad++; $display("FAIL exact_vend_latency got=%b want=1", b.vendeu); end
    @(negedge clk);
    total++; if (b.vendeu !== 1'b0 || b.soma !== 7'd0 || b.busy !== 1'b0 || b.chg_valid !== 1'b0) begin
      bad++; $display("FAIL exact_after got vendeu=%b soma=%0d busy=%b chg_valid=%b want 0,0,0,0", b.vendeu, b.soma, b.busy, b.chg_valid);
    end
    total++; if (n_vend - v0 !== 1) begin bad++; $display("FAIL exact_vend_count got=%0d want=1", n_vend - v0); end
  endtask

  task automatic test_vend_change();
    logic rej;
    b.price = 7'd25;
    put_coin(5'd20, rej);
    wait_idle(0);
    put_coin(5'd10, rej);
    @(negedge clk);
    total++; if (b.vendeu !== 1'b1 || b.soma !== 7'd30) begin
      bad++; $display("FAIL change_vend got vendeu=%b soma=%0d want 1,30", b.vendeu, b.soma);
    end
    @(negedge clk);
    total++; if (b.chg_valid !== 1'b1 || b.chg_coin !== 5'd5 || b.soma !== 7'd5) begin
      bad++; $display("FAIL change_coin got valid=%b coin=%0d soma=%0d want 1,5,5", b.chg_valid, b.chg_coin, b.soma);
    end
    b.chg_ready = 1'b1;
    @(negedge clk);
    b.chg_ready = 1'b0;
    total++; if (b.soma !== 7'd0 || b.busy !== 1'b0 || b.chg_valid !== 1'b0) begin
      bad++; $display("FAIL change_done got soma=%0d busy=%b valid=%b want 0,0,0", b.soma, b.busy, b.chg_valid);
    end
  endtask

  task automatic test_cancel();
    logic rej;
    int v0;
    v0 = n_vend;
    b.price = 7'd40;
    put_coin(5'd10, rej);
    wait_idle(0);
    put_coin(5'd5, rej);
    wait_idle(0);
    chg_q.delete();
    do_cancel(rej);
    total++; if (b.chg_valid !== 1'b1 || b.chg_coin !== 5'd10 || b.soma !== 7'd15) begin
      bad++; $display("FAIL cancel_first got valid=%b coin=%0d soma=%0d want 1,10,15", b.chg_valid, b.chg_coin, b.soma);
    end
    wait_idle(0);
    total++; if (chg_q.size() != 2 || chg_q[0] !== 5'd10 || chg_q[1] !== 5'd5) begin
      bad++; $display("FAIL cancel_refund got n=%0d want 10,5", chg_q.size());
    end
    total++; if (n_vend != v0 || b.soma !== 7'd0) begin
      bad++; $display("FAIL cancel_novend got vends=%0d soma=%0d want 0,0", n_vend - v0, b.soma);
    end
  endtask

  task automatic test_reject();
    logic rej;
    put_coin(5'd7, rej);
    total++; if (rej !== 1'b1 || b.soma !== 7'd0 || b.busy !== 1'b0) begin
      bad++; $display("FAIL reject_illegal got reject=%b soma=%0d busy=%b want 1,0,0", rej, b.soma, b.busy);
    end
    do_cancel(rej);
    total++; if (b.busy !== 1'b0 || b.chg_valid !== 1'b0) begin
      bad++; $display("FAIL cancel_empty got busy=%b valid=%b want 0,0", b.busy, b.chg_valid);
    end
  endtask

  task automatic test_overflow();
    logic rej;
    b5.price = 5'd31;
    put_coin5(5'd20, rej);
    total++; if (rej !== 1'b0) begin bad++; $display("FAIL ovf_first got reject=%b want=0", rej); end
    put_coin5(5'd10, rej);
    total++; if (rej !== 1'b0) begin bad++; $display("FAIL ovf_30 got reject=%b want=0", rej); end
    put_coin5(5'd5, rej);
    total++; if (rej !== 1'b1 || b5.soma !== 5'd30) begin
      bad++; $display("FAIL ovf_35 got reject=%b soma=%0d want 1,30", rej, b5.soma);
    end
    @(negedge clk);
    b5.cancel = 1'b1;
    @(negedge clk);
    b5.cancel = 1'b0;
    total++; if (b5.chg_coin !== 5'd20 || b5.vendeu !== 1'b0) begin
      bad++; $display("FAIL ovf_refund got coin=%0d vendeu=%b want 20,0", b5.chg_coin, b5.vendeu);
    end
    b5.chg_ready = 1'b1;
    for (int i = 0; i < 20 && b5.busy !== 1'b0; i++) @(negedge clk);
    b5.chg_ready = 1'b0;
    total++; if (b5.soma !== 5'd0 || b5.busy !== 1'b0) begin
      bad++; $display("FAIL ovf_done got soma=%0d busy=%b want 0,0", b5.soma, b5.busy);
    end
  endtask

  task automatic test_stall_reset();
    logic rej;
    b.price = 7'd40;
    put_coin(5'd20, rej);
    wait_idle(0);
    @(negedge clk);
    b.cancel = 1'b1; b.coin = 5'd10; b.coin_valid = 1'b1;
    @(negedge clk);
    b.cancel = 1'b0; b.coin_valid = 1'b0;
    total++; if (b.coin_reject !== 1'b1 || b.soma !== 7'd20 || b.chg_coin !== 5'd20) begin
      bad++; $display("FAIL cancel_wins got reject=%b soma=%0d coin=%0d want 1,20,20", b.coin_reject, b.soma, b.chg_coin);
    end
    b.coin = 5'd20; b.coin_valid = 1'b1;
    @(negedge clk);
    b.coin_valid = 1'b0;
    total++; if (b.coin_reject !== 1'b1 || b.soma !== 7'd20 || b.busy !== 1'b1) begin
      bad++; $display("FAIL busy_reject got reject=%b soma=%0d busy=%b want 1,20,1", b.coin_reject, b.soma, b.busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (b.chg_valid !== 1'b1 || b.chg_coin !== 5'd20 || b.soma !== 7'd20) begin
        bad++; $display("FAIL stall_%0d got valid=%b coin=%0d soma=%0d want 1,20,20", i, b.chg_valid, b.chg_coin, b.soma);
      end
    end
    reset = 1'b0;
    #1;
    total++; if (b.soma !== 7'd0 || b.busy !== 1'b0 || b.chg_valid !== 1'b0) begin
      bad++; $display("FAIL midreset got soma=%0d busy=%b valid=%b want 0,0,0", b.soma, b.busy, b.chg_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++; if (b.coin_ready !== 1'b1 || b.soma !== 7'd0) begin
      bad++; $display("FAIL midreset_release got ready=%b soma=%0d want 1,0", b.coin_ready, b.soma);
    end
  endtask

  task automatic test_random(input int steps);
    int m_soma, m_price, p, act, c, v0;
    bit exp_rej, exp_vend, ok;
    logic rej;
    m_soma = 0;
    m_price = 0;
    for (int i = 0; i < steps; i++) begin
      exp_q.delete();
      chg_q.delete();
      v0 = n_vend;
      exp_rej = 1'b0;
      exp_vend = 1'b0;
      p = $urandom_range(0, 60);
      b.price = 7'(p);
      act = $urandom_range(0, 9);
      if (act == 9) begin
        do_cancel(rej);
        if (m_soma > 0) begin model_change(m_soma); m_soma = 0; end
      end else begin
        c = (act < 3) ? 5 : (act < 6) ? 10 : (act < 8) ? 20 : $urandom_range(0, 31);
        put_coin(5'(c), rej);
        if ((c == 5 || c == 10 || c == 20) && (m_soma + c <= 127)) begin
          if (m_soma == 0) m_price = p;
          m_soma += c;
          if (m_price != 0 && m_soma >= m_price) begin
            exp_vend = 1'b1;
            model_change(m_soma - m_price);
            m_soma = 0;
          end
        end else begin
          exp_rej = 1'b1;
        end
      end
      wait_idle(1);
      total++; if (rej !== exp_rej) begin bad++; $display("FAIL rnd%0d_reject got=%b want=%b", i, rej, exp_rej); end
      total++; if (n_vend - v0 != int'(exp_vend)) begin
        bad++; $display("FAIL rnd%0d_vend got=%0d want=%0d", i, n_vend - v0, exp_vend);
      end
      ok = (chg_q.size() == exp_q.size());
      for (int k = 0; ok && k < exp_q.size(); k++) if (chg_q[k] !== 5'(exp_q[k])) ok = 1'b0;
      total++; if (!ok) begin
        bad++; $display("FAIL rnd%0d_change got n=%0d want n=%0d", i, chg_q.size(), exp_q.size());
      end
      total++; if (b.soma !== 7'(m_soma)) begin bad++; $display("FAIL rnd%0d_soma got=%0d want=%0d", i, b.soma, m_soma); end
    end
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_cancel();
    test_reject();
    test_overflow();
    test_stall_reset();
    test_random(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
